// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - UART receive-path parity checker
//
// Captures the data bits of one serial frame by bit index, then compares the
// received parity bit against even/odd parity over those bits.
//
// Ports:
//   CLK                    in   system clock, rising edge
//   RST                    in   synchronous active-high reset
//   PAR_TYP                in   0 = even parity, 1 = odd parity
//   parity_checker_enable  in   qualifies bit_cnt/sampled_data this cycle
//   bit_cnt [3:0]          in   0=start, 1..DATA_WIDTH=data (LSB first),
//                               DATA_WIDTH+1=parity, above=stop/unused
//   sampled_data           in   sampled serial bit for index bit_cnt
//   parity_err             out  registered parity mismatch flag
module parity_checker #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PAR_TYP,
  input  logic       parity_checker_enable,
  input  logic [3:0] bit_cnt,
  input  logic       sampled_data,
  output logic       parity_err
);

  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_WIDTH);
  localparam logic [3:0] PARITY_IDX    = 4'(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] data;
  logic                  expected_parity;

  // Parity bit value that would make the frame valid for the selected type.
  assign expected_parity = (^data) ^ PAR_TYP;

  always_ff @(posedge CLK) begin
    if (RST) begin
      data       <= '0;
      parity_err <= 1'b0;
    end else if (parity_checker_enable) begin
      if (bit_cnt == 4'd0) begin
        // Start bit: clear any state left by the previous frame.
        data       <= '0;
        parity_err <= 1'b0;
      end else if (bit_cnt <= LAST_DATA_IDX) begin
        // bit_cnt is 1-based for data bits; rewrites of an index overwrite it.
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (bit_cnt == 4'(i + 1)) begin
            data[i] <= sampled_data;
          end
        end
      end else if (bit_cnt == PARITY_IDX) begin
        parity_err <= (sampled_data != expected_parity);
      end
      // Stop bit and unused codes leave all state untouched.
    end
  end

endmodule

// File: tb/tb_parity_checker.sv
// tb/tb_parity_checker.sv - directed self-checking bench for parity_checker
module tb_parity_checker;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PAR_TYP;
  logic       parity_checker_enable;
  logic [3:0] bit_cnt;
  logic       sampled_data;
  logic       parity_err;

  int checks   = 0;
  int failures = 0;

  // Data bits 1..8 = 1,1,0,0,1,1,0,1 (LSB = bit 1); five ones.
  localparam logic [7:0] FRAME_DATA = 8'hB3;

  parity_checker #(.DATA_WIDTH(8)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .PAR_TYP              (PAR_TYP),
    .parity_checker_enable(parity_checker_enable),
    .bit_cnt              (bit_cnt),
    .sampled_data         (sampled_data),
    .parity_err           (parity_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic exp);
    checks++;
    assert (parity_err === exp)
    else begin
      failures++;
      $error("FAIL %s: parity_err=%b expected=%b", tag, parity_err, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic step(input logic en, input logic [3:0] cnt, input logic sd);
    parity_checker_enable = en;
    bit_cnt               = cnt;
    sampled_data          = sd;
    @(posedge CLK);
    #1;
    parity_checker_enable = 1'b0;
  endtask

  task automatic data_bits(input logic [7:0] d, input logic gate_toggle);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'(i + 1), d[i]);
      if (gate_toggle) begin
        step(1'b0, 4'(i + 1), ~d[i]);
        step(1'b0, 4'd9, ~d[i]);
      end
    end
  endtask

  task automatic frame(input logic typ, input logic [7:0] d, input logic pbit,
                       input logic gate_toggle);
    PAR_TYP = typ;
    step(1'b1, 4'd0, 1'b0);
    data_bits(d, gate_toggle);
    step(1'b1, 4'd9, pbit);
  endtask

  initial begin
    RST = 1'b1;
    PAR_TYP = 1'b0;
    parity_checker_enable = 1'b0;
    bit_cnt = 4'd0;
    sampled_data = 1'b0;
    @(posedge CLK);
    #1;
    check("reset", 1'b0);
    RST = 1'b0;

    // Even frame, correct parity bit.
    frame(1'b0, FRAME_DATA, 1'b1, 1'b0);
    check("even_ok", 1'b0);
    step(1'b1, 4'd10, 1'b1);
    check("even_ok_stop", 1'b0);

    // Even frame, wrong parity bit; flag holds through stop, idle, unused code.
    frame(1'b0, FRAME_DATA, 1'b0, 1'b0);
    check("even_bad", 1'b1);
    step(1'b1, 4'd10, 1'b1);
    check("even_bad_stop", 1'b1);
    step(1'b0, 4'd0, 1'b0);
    check("even_bad_idle", 1'b1);
    step(1'b1, 4'd15, 1'b0);
    check("even_bad_unused", 1'b1);
    // Gated parity-bit cycle that would clear the flag if it were honoured.
    step(1'b0, 4'd9, 1'b1);
    check("gated_parity_hold", 1'b1);

    // Start bit clears, then all-zero data with even parity bit 0.
    step(1'b1, 4'd0, 1'b0);
    check("start_clear", 1'b0);
    frame(1'b0, 8'h00, 1'b0, 1'b0);
    check("zero_even_ok", 1'b0);

    // Latency and no combinational path: flag changes only after the edge.
    PAR_TYP = 1'b0;
    step(1'b1, 4'd0, 1'b0);
    data_bits(FRAME_DATA, 1'b0);
    parity_checker_enable = 1'b1;
    bit_cnt = 4'd9;
    sampled_data = 1'b0;
    #1;
    check("no_comb_path", 1'b0);
    @(posedge CLK);
    #1;
    parity_checker_enable = 1'b0;
    check("latency_one_edge", 1'b1);

    // Odd frames.
    frame(1'b1, FRAME_DATA, 1'b0, 1'b0);
    check("odd_ok", 1'b0);
    frame(1'b1, FRAME_DATA, 1'b1, 1'b0);
    check("odd_bad", 1'b1);

    // Reset overrides a parity-bit cycle that would set the flag.
    RST = 1'b1;
    step(1'b1, 4'd9, 1'b1);
    check("reset_override", 1'b0);
    RST = 1'b0;

    // Gating: sampled_data toggles with enable=0 between data cycles.
    frame(1'b0, FRAME_DATA, 1'b1, 1'b1);
    check("gating_even_ok", 1'b0);

    // Last write wins: bit 1 rewritten to 0 leaves four ones, even parity 0.
    PAR_TYP = 1'b0;
    step(1'b1, 4'd0, 1'b0);
    data_bits(FRAME_DATA, 1'b0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    check("overwrite_bit", 1'b0);

    // Reset mid-frame clears the captured bits.
    PAR_TYP = 1'b0;
    step(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(i + 1), FRAME_DATA[i]);
    end
    RST = 1'b1;
    step(1'b1, 4'd5, 1'b1);
    check("reset_mid_frame", 1'b0);
    RST = 1'b0;
    step(1'b1, 4'd9, 1'b1);
    check("after_reset_zero_data", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
